// File: rtl/rat_ckpt.sv
// Register alias table with multi-slot rename, intra-group bypass, branch checkpoints
// and a committed map used to rebuild the speculative map on a full flush.
module rat_ckpt #(
  parameter int unsigned NUM_ARCH_REGS = 35,
  parameter int unsigned NUM_PHYS_REGS = 64,
  parameter int unsigned NUM_RENAME    = 2,
  parameter int unsigned NUM_COMMIT    = 2,
  parameter int unsigned NUM_CKPT      = 4,
  localparam int unsigned LA = $clog2(NUM_ARCH_REGS),
  localparam int unsigned LP = $clog2(NUM_PHYS_REGS),
  localparam int unsigned LC = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [NUM_RENAME-1:0]      ren_valid,
  input  logic [NUM_RENAME*LA-1:0]   ren_src1_arch,
  input  logic [NUM_RENAME*LA-1:0]   ren_src2_arch,
  input  logic [NUM_RENAME-1:0]      ren_dst_we,
  input  logic [NUM_RENAME*LA-1:0]   ren_dst_arch,
  input  logic [NUM_RENAME*LP-1:0]   ren_new_phys,
  output logic [NUM_RENAME*LP-1:0]   ren_src1_phys,
  output logic [NUM_RENAME*LP-1:0]   ren_src2_phys,
  output logic [NUM_RENAME*LP-1:0]   ren_old_phys,
  input  logic                       ckpt_take,
  output logic                       ckpt_ok,
  output logic [LC-1:0]              ckpt_id,
  input  logic                       ckpt_restore,
  input  logic [LC-1:0]              ckpt_restore_id,
  input  logic                       ckpt_release,
  input  logic [LC-1:0]              ckpt_release_id,
  input  logic [NUM_COMMIT-1:0]      commit_valid,
  input  logic [NUM_COMMIT*LA-1:0]   commit_dst_arch,
  input  logic [NUM_COMMIT*LP-1:0]   commit_phys,
  input  logic                       flush,
  output logic [LC:0]                ckpt_free_cnt
);

  typedef logic [LP-1:0] physT;

  physT regPtrs [NUM_ARCH_REGS];
  physT specD   [NUM_ARCH_REGS];
  physT renMap  [NUM_ARCH_REGS];
  physT commQ   [NUM_ARCH_REGS];
  physT commD   [NUM_ARCH_REGS];
  physT ckptQ   [NUM_CKPT][NUM_ARCH_REGS];

  logic [NUM_CKPT-1:0] busyQ, busyD;
  logic [LC:0]         freeCntQ, freeCntD;
  logic                takeEn;

  logic [LA-1:0] src1A [NUM_RENAME];
  logic [LA-1:0] src2A [NUM_RENAME];
  logic [LA-1:0] dstA  [NUM_RENAME];
  physT          newA  [NUM_RENAME];
  logic [NUM_RENAME-1:0] renWr;
  physT src1P [NUM_RENAME];
  physT src2P [NUM_RENAME];
  physT oldP  [NUM_RENAME];

  // Arch reg 0 and out-of-range indices never touch the maps.
  function automatic logic mapped(input logic [LA-1:0] a);
    return (a != '0) && (32'(a) < NUM_ARCH_REGS);
  endfunction

  always_comb begin
    for (int j = 0; j < NUM_RENAME; j++) begin
      src1A[j] = ren_src1_arch[j*LA +: LA];
      src2A[j] = ren_src2_arch[j*LA +: LA];
      dstA[j]  = ren_dst_arch[j*LA +: LA];
      newA[j]  = ren_new_phys[j*LP +: LP];
      renWr[j] = ren_valid[j] & ren_dst_we[j] & mapped(ren_dst_arch[j*LA +: LA]);
    end
  end

  // Older slots in the group override the table; ascending scan leaves the youngest match.
  always_comb begin
    ren_src1_phys = '0;
    ren_src2_phys = '0;
    ren_old_phys  = '0;
    for (int j = 0; j < NUM_RENAME; j++) begin
      src1P[j] = mapped(src1A[j]) ? regPtrs[src1A[j]] : '0;
      src2P[j] = mapped(src2A[j]) ? regPtrs[src2A[j]] : '0;
      oldP[j]  = mapped(dstA[j])  ? regPtrs[dstA[j]]  : '0;
      for (int i = 0; i < j; i++) begin
        if (renWr[i] && dstA[i] == src1A[j]) src1P[j] = newA[i];
        if (renWr[i] && dstA[i] == src2A[j]) src2P[j] = newA[i];
        if (renWr[i] && dstA[i] == dstA[j])  oldP[j]  = newA[i];
      end
      ren_src1_phys[j*LP +: LP] = src1P[j];
      ren_src2_phys[j*LP +: LP] = src2P[j];
      ren_old_phys[j*LP +: LP]  = oldP[j];
    end
  end

  always_comb begin
    ckpt_ok = ~&busyQ;
    ckpt_id = '0;
    for (int k = NUM_CKPT - 1; k >= 0; k--) begin
      if (!busyQ[k]) ckpt_id = LC'(k);
    end
    takeEn = ckpt_take & ckpt_ok & ~flush & ~ckpt_restore;
  end

  always_comb begin
    renMap = regPtrs;
    for (int j = 0; j < NUM_RENAME; j++) begin
      if (renWr[j]) renMap[dstA[j]] = newA[j];
    end
    commD = commQ;
    for (int k = 0; k < NUM_COMMIT; k++) begin
      if (commit_valid[k] && mapped(commit_dst_arch[k*LA +: LA])) begin
        commD[commit_dst_arch[k*LA +: LA]] = commit_phys[k*LP +: LP];
      end
    end
    if (flush)             specD = commD;
    else if (ckpt_restore) specD = ckptQ[ckpt_restore_id];
    else                   specD = renMap;
  end

  // Release is applied before take so a take can never be undone by a stale release.
  always_comb begin
    busyD = busyQ;
    if (flush) begin
      busyD = '0;
    end else begin
      if (ckpt_release) busyD[ckpt_release_id] = 1'b0;
      if (ckpt_restore) busyD[ckpt_restore_id] = 1'b0;
      if (takeEn)       busyD[ckpt_id]         = 1'b1;
    end
    freeCntD = '0;
    for (int k = 0; k < NUM_CKPT; k++) begin
      if (!busyD[k]) freeCntD = freeCntD + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_ARCH_REGS; i++) begin
        regPtrs[i] <= LP'(i);
        commQ[i]   <= LP'(i);
      end
      busyQ    <= '0;
      freeCntQ <= (LC+1)'(NUM_CKPT);
    end else begin
      regPtrs  <= specD;
      commQ    <= commD;
      busyQ    <= busyD;
      freeCntQ <= freeCntD;
    end
  end

  always_ff @(posedge CLK) begin
    if (takeEn) ckptQ[ckpt_id] <= renMap;
  end

  assign ckpt_free_cnt = freeCntQ;

endmodule

// File: doc/rat_ckpt.md
Name: rat_ckpt

Overview:
- Parametrised successor to the single-port register alias table.
- Renames up to NUM_RENAME instructions per cycle, with intra-group dependency bypass.
- Keeps NUM_CKPT branch checkpoints of the speculative map for single-cycle mispredict recovery.
- Holds a committed (retirement) map, updated by commit ports and copied into the speculative map on a full pipeline flush. Sits between decode and dispatch.

Parameters:
- NUM_ARCH_REGS, 35: architectural registers. LO=33, HI=34; reg 0 is hardwired.
- NUM_PHYS_REGS, 64: physical registers. LP = clog2(NUM_PHYS_REGS).
- NUM_RENAME, 2: rename slots per cycle. Slot 0 is oldest.
- NUM_COMMIT, 2: commit slots per cycle. Slot 0 is oldest.
- NUM_CKPT, 4: checkpoint slots. LC = clog2(NUM_CKPT), minimum 1.
- LA = clog2(NUM_ARCH_REGS), derived.

Ports:
- CLK  in  1  clock.
- RESET  in  1  asynchronous, active-high reset.
- ren_valid  in  NUM_RENAME  slot valid.
- ren_src1_arch, ren_src2_arch  in  NUM_RENAME*LA  source arch regs.
- ren_dst_we  in  NUM_RENAME  slot writes a destination.
- ren_dst_arch  in  NUM_RENAME*LA  destination arch reg.
- ren_new_phys  in  NUM_RENAME*LP  free physical reg from the free list.
- ren_src1_phys, ren_src2_phys  out  NUM_RENAME*LP  mapped sources (combinational).
- ren_old_phys  out  NUM_RENAME*LP  previous mapping of dst, for freeing at commit (combinational).
- ckpt_take  in  1  snapshot the map after this cycle's renames.
- ckpt_ok  out  1  combinational; a free slot exists (take accepted).
- ckpt_id  out  LC  slot that a take this cycle will use (lowest free).
- ckpt_restore  in  1  mispredict; restore a checkpoint.
- ckpt_restore_id  in  LC  checkpoint to restore.
- ckpt_release  in  1  branch resolved correct; free a slot.
- ckpt_release_id  in  LC  slot to free.
- commit_valid  in  NUM_COMMIT  commit slot valid.
- commit_dst_arch  in  NUM_COMMIT*LA  committed destination arch reg.
- commit_phys  in  NUM_COMMIT*LP  committed physical reg.
- flush  in  1  full flush; speculative map := committed map.
- ckpt_free_cnt  out  LC+1  registered count of free checkpoint slots.

Behaviour:
- Reset (async): spec[i] = i and comm[i] = i for all i. All checkpoints free. ckpt_free_cnt = NUM_CKPT. Checkpoint contents are don't-care.
- Arch reg 0:
  - Reads always return phys 0.
  - A rename or commit with dst 0 is ignored: no map write, old_phys = 0, and no bypass to younger slots.
- Source lookup, slot j: result is ren_new_phys of the youngest slot i<j with ren_valid & ren_dst_we and dst == src. Otherwise spec[src].
- ren_old_phys, slot j: same bypass rule applied to ren_dst_arch[j]. This is zero-cycle latency; outputs are valid in the same cycle.
- Map update at the clock edge, for each valid writing slot: spec[dst] <= new_phys. If several slots share a dst, the youngest slot wins.
- Commit: comm[dst] <= phys for each valid slot. Same dst in several slots: the youngest slot wins. Commit applies in every cycle, including flush and restore cycles.
- Checkpoint take:
  - With ckpt_ok, slot ckpt_id <= the post-rename spec map and is marked busy.
  - When all slots are busy (ckpt_ok = 0), the take is ignored and the front end must stall.
- Release: marks the slot free. Releasing a free slot is a no-op.
- Take and release in the same cycle:
  - Both apply.
  - A released slot is not reusable until the next cycle; ckpt_id is computed from the registered free mask.
- Restore: spec <= ckpt[ckpt_restore_id] and the slot is freed. Renames and takes in that cycle are discarded. Freeing younger checkpoints is the controller's job, via release. Restoring a free slot is a protocol error; the bench asserts against it.
- Flush: spec <= comm. The comm value used includes this cycle's commits. All checkpoints are freed. Renames, takes, restores and releases in that cycle are discarded.
- Priority: RESET > flush > restore > rename/take. Release is independent except under flush.
- ckpt_free_cnt = NUM_CKPT minus the busy count, registered.
- Storage is flops. Expose spec as regPtrs (verilator public_flat) so sim_main can read LO/HI.

Test Plan:
- Reset, then read srcs 5 and 34 -> phys 5 and 34; ckpt_free_cnt = 4; ckpt_id = 0.
- Same cycle: slot0 r3->40, slot1 src1=r3 dst=r3 new=41 -> slot1 src1 = 40, old_phys = 40. Next cycle a read of r3 returns 41.
- Rename r7->50, take ckpt (id 0), rename r7->51, restore 0 -> r7 reads 50; ckpt_free_cnt back to 4. A rename issued in the restore cycle does not appear.
- Take 4 checkpoints -> ckpt_ok = 0, fifth take ignored. Release 2 -> next cycle ckpt_id = 2, ckpt_ok = 1.
- Commit r9->60, speculative r9->61, then flush with a same-cycle commit r10->62 -> r9 reads 60, r10 reads 62, ckpt_free_cnt = 4.
- Rename dst r0 with new=45 and slot1 src r0 -> src reads 0, old_phys = 0, map unchanged. Assert RESET mid-rename -> identity map immediately.
